// File: rtl/seven_seg_scan_decoder.sv
// Receive-side decoder for a multiplexed active-low seven-segment scan.
// Filters each {an,seg} value for stability, then recovers per-digit BCD, dp and blank flags.
module seven_seg_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [7:0]              seg,
    input  logic [NUM_DIGITS-1:0]   an,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   dp,
    output logic [NUM_DIGITS-1:0]   blank,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    frame_valid,
    output logic                    err_multi,
    output logic                    err_pattern
);

    localparam int RAW_W = NUM_DIGITS + 8;
    localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] PRE    = CNT_W'(STABLE_CYCLES - 1);

    logic [RAW_W-1:0]      raw;
    logic [RAW_W-1:0]      sample_q;
    logic [CNT_W-1:0]      cnt;
    logic                  accept;
    logic [NUM_DIGITS-1:0] an_low;
    logic                  multi_low;
    logic                  single_low;
    logic                  capture;
    logic [NUM_DIGITS-1:0] cap_mask;
    logic [NUM_DIGITS-1:0] seen;
    logic [NUM_DIGITS-1:0] seen_next;
    logic                  frame_done;
    logic [3:0]            dec_val;
    logic                  dec_legal;
    logic                  is_blank;

    assign raw = {an, seg};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sample_q <= '1;
            cnt      <= STABLE;
        end else if (raw != sample_q) begin
            sample_q <= raw;
            cnt      <= CNT_W'(1);
        end else if (cnt < STABLE) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // cnt saturates at STABLE, so this fires once per hold however long it lasts
    assign accept = (raw == sample_q) && (cnt == PRE);

    assign an_low     = ~sample_q[RAW_W-1:8];
    assign multi_low  = (an_low & (an_low - NUM_DIGITS'(1))) != '0;
    assign single_low = (an_low != '0) && !multi_low;
    assign capture    = accept && single_low;
    assign cap_mask   = capture ? an_low : '0;
    assign seen_next  = seen | cap_mask;
    assign frame_done = capture && (seen_next == '1);
    assign is_blank   = (sample_q[6:0] == 7'h7F);

    // Patterns are matched with dp forced off, i.e. against seg[6:0] alone
    always_comb begin
        dec_val   = 4'hF;
        dec_legal = 1'b1;
        case (sample_q[6:0])
            7'h40:   dec_val = 4'd0;
            7'h79:   dec_val = 4'd1;
            7'h24:   dec_val = 4'd2;
            7'h30:   dec_val = 4'd3;
            7'h19:   dec_val = 4'd4;
            7'h12:   dec_val = 4'd5;
            7'h02:   dec_val = 4'd6;
            7'h78:   dec_val = 4'd7;
            7'h00:   dec_val = 4'd8;
            7'h10:   dec_val = 4'd9;
            default: dec_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            digits      <= '0;
            dp          <= '0;
            blank       <= '0;
            digit_valid <= '0;
            seen        <= '0;
            frame_valid <= 1'b0;
            err_multi   <= 1'b0;
            err_pattern <= 1'b0;
        end else begin
            frame_valid <= frame_done;
            err_multi   <= accept && multi_low;
            err_pattern <= capture && !dec_legal && !is_blank;
            if (capture) begin
                seen <= frame_done ? '0 : seen_next;
            end
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (cap_mask[i]) begin
                    digits[4*i +: 4] <= dec_legal ? dec_val : 4'hF;
                    dp[i]            <= ~sample_q[7];
                    digit_valid[i]   <= dec_legal;
                    blank[i]         <= is_blank;
                end
            end
        end
    end

endmodule

// File: doc/seven_seg_scan_decoder.md
Name: seven_seg_scan_decoder

Overview:
Receive-side counterpart of the board's multiplexed seven-segment driver. Samples the active-low seg/an lines that the display driver produces, waits for each scanned pattern to settle, and decodes it back into per-digit BCD values, decimal-point flags and blank flags. Signals when a complete scan frame has been seen. Used as an on-chip self-check monitor of display output, and to drive a loopback check of the display path.

Parameters:
NUM_DIGITS, 4, number of anodes scanned. The bench exercises only 4.
STABLE_CYCLES, 4, consecutive clock edges a {an,seg} value must be held before it is accepted. Legal range is 2..255.
CNT_W, 8, width of the stability counter. Must satisfy 2^CNT_W > STABLE_CYCLES.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
seg  in  8  active-low segments. Bit 7 is dp; bits 6:0 are g,f,e,d,c,b,a.
an  in  NUM_DIGITS  active-low anode selects
digits  out  4*NUM_DIGITS  decoded value. Slice [4i+3:4i] belongs to an[i].
dp  out  NUM_DIGITS  dp[i]=1 means the decimal point is lit for digit i
blank  out  NUM_DIGITS  seg[6:0]=7'h7F was captured for digit i
digit_valid  out  NUM_DIGITS  the last capture for digit i was a legal 0-9 pattern
frame_valid  out  1  one-cycle pulse when every digit has been captured since the last pulse
err_multi  out  1  one-cycle pulse: an accepted value had more than one anode low
err_pattern  out  1  one-cycle pulse: an accepted single-anode value had an illegal pattern

Behaviour:
- Reset (asynchronous, immediate on assertion):
  - digits=0, dp=0, blank=0, digit_valid=0, frame_valid=0, err_multi=0, err_pattern=0.
  - Seen-mask=0. Internal sample_q={all ones}. cnt=STABLE_CYCLES.
- Stability filter, evaluated at each edge on raw={an,seg}:
  - raw!=sample_q: sample_q<=raw, cnt<=1.
  - raw==sample_q and cnt<STABLE_CYCLES: cnt<=cnt+1.
  - Otherwise cnt holds (saturates).
- Accept event: the edge where cnt goes from STABLE_CYCLES-1 to STABLE_CYCLES. Exactly one accept per hold, however long the hold lasts.
- Latency: a value first present before edge 0 and held through edge STABLE_CYCLES-1 updates its outputs at edge STABLE_CYCLES-1. A change before that edge restarts the count, so shorter glitches are ignored.
- On accept, classify an:
  - All ones: idle. No capture, no error.
  - Exactly one zero at index i: capture into slot i.
  - Two or more zeros: err_multi=1 for one cycle. No capture; the seen-mask is unchanged.
- Capture into slot i:
  - dp[i] <= ~seg[7].
  - Decode seg[6:0] using the pattern with seg[7] forced to 1: C0->0, F9->1, A4->2, B0->3, 99->4, 92->5, 82->6, F8->7, 80->8, 90->9.
  - Legal pattern: digits slice <= value, digit_valid[i]=1, blank[i]=0.
  - seg[6:0]=7F: digits slice <= 4'hF, digit_valid[i]=0, blank[i]=1. Not an error.
  - Any other pattern: digits slice <= 4'hF, digit_valid[i]=0, blank[i]=0, err_pattern=1 for one cycle.
  - Set seen-mask bit i in every capture case.
- Frame completion: when the capture makes the seen-mask all ones, frame_valid=1 on that same edge and the seen-mask is cleared to 0 on that edge. Re-capturing an already-seen slot only updates that slot's outputs.
- All outputs are registered. Error and frame pulses are high for exactly one cycle and are independent of each other.
- Reset asserted mid-hold: the count is lost. After release, the held value must persist STABLE_CYCLES fresh edges before it is accepted.

Test Plan:
1. Reset, then seg=C0, an=1110 held for 4 edges -> after edge 3: digits[3:0]=0, digit_valid=0001, dp=0, blank=0. No frame_valid pulse. Holding 10 more edges produces no further events.
2. Scan an=1110/1101/1011/0111 with seg=F9/A4/B0/99, 4 edges each -> digits=16'h4321, digit_valid=1111. frame_valid pulses exactly once, at the 4th capture edge. Repeating the scan gives a second single pulse.
3. seg=92 on an=1101 held for only 3 edges, then an=1111 -> no output change, no pulses. Held for 4 edges -> digits[7:4]=5.
4. an=1100, seg=C0 held for 4 edges -> err_multi single pulse; digits, digit_valid and the seen-mask are unchanged.
5. Illegal and special patterns:
   - seg=C1 on an=1011 -> err_pattern single pulse, digits[11:8]=F, digit_valid[2]=0.
   - seg=7F on an=1011 -> blank[2]=1, no error.
   - seg=00 on an=1011 -> digits[11:8]=8, dp[2]=1.
6. Reset asserted after 2 edges of a hold and released while the input is still held -> outputs zero immediately. Capture occurs only after 4 post-release edges.
